// File: rtl/scan_pattern_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : scan_pattern_ctrl
// Purpose  : Tester-side scan sequencer. Runs one test per start request:
//            it shifts a pattern into the chain, applies one capture cycle,
//            shifts the response out, and compares the response against an
//            expected vector under a mask.
// Ports    : CK            - clock shared with the chain under test
//            RN            - asynchronous reset, active low
//            start         - one-cycle request to run a test (IDLE only)
//            abort         - terminates any running test, priority over start
//            pat_in        - stimulus, bit i -> chain position i
//            exp_in        - expected captured value per position
//            mask_in       - 1 = compare position, 0 = don't care
//            scan_data_out - chain serial output (last flop Q)
//            scan_enable   - 1 = chain shifts, 0 = functional capture
//            scan_data_in  - serial data into the chain
//            busy          - test in progress (SHIFT_IN..SHIFT_OUT)
//            done          - one-cycle completion pulse
//            pass          - compare result, held until the next done
//            resp_out      - captured response, bit i = chain position i
// Revision : 1.0 - initial release
// ============================================================================
module scan_pattern_ctrl #(
  parameter int CHAIN_LEN = 16,
  parameter int CNT_W     = 6
) (
  input  logic                 CK,
  input  logic                 RN,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CHAIN_LEN-1:0] pat_in,
  input  logic [CHAIN_LEN-1:0] exp_in,
  input  logic [CHAIN_LEN-1:0] mask_in,
  input  logic                 scan_data_out,
  output logic                 scan_enable,
  output logic                 scan_data_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CHAIN_LEN-1:0] resp_out
);

  localparam logic [CNT_W-1:0] c_last = CNT_W'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SHIFT_IN  = 3'd1,
    S_CAPTURE   = 3'd2,
    S_SHIFT_OUT = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  // Working copy of the pattern; shifted left so the next serial bit is
  // always at the MSB, avoiding a variable bit select.
  logic [CHAIN_LEN-1:0] r_pat, w_pat_nxt;
  logic [CHAIN_LEN-1:0] r_exp, w_exp_nxt;
  logic [CHAIN_LEN-1:0] r_mask, w_mask_nxt;
  logic [CHAIN_LEN-1:0] r_resp, w_resp_nxt;
  logic [CHAIN_LEN-1:0] r_resp_out, w_resp_out_nxt;
  logic                 r_se, w_se_nxt;
  logic                 r_sdi, w_sdi_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_done, w_done_nxt;
  logic                 r_pass, w_pass_nxt;

  // The first bit out of the chain is the one furthest from scan_data_in,
  // so shifting in at the LSB lands it at resp[CHAIN_LEN-1].
  logic [CHAIN_LEN-1:0] w_resp_shift;
  logic                 w_cmp_ok;

  assign w_resp_shift = {r_resp[CHAIN_LEN-2:0], scan_data_out};
  // Compare against the response including the bit sampled this edge, so
  // pass is valid in the same cycle done rises.
  assign w_cmp_ok     = ~|((w_resp_shift ^ r_exp) & r_mask);

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_pat      <= '0;
      r_exp      <= '0;
      r_mask     <= '0;
      r_resp     <= '0;
      r_resp_out <= '0;
      r_se       <= 1'b0;
      r_sdi      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pat      <= w_pat_nxt;
      r_exp      <= w_exp_nxt;
      r_mask     <= w_mask_nxt;
      r_resp     <= w_resp_nxt;
      r_resp_out <= w_resp_out_nxt;
      r_se       <= w_se_nxt;
      r_sdi      <= w_sdi_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_pass     <= w_pass_nxt;
    end
  end

  // Next-state and next-output logic. All outputs are registered, so each
  // branch sets the values the outputs must carry in the *next* state.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_pat_nxt      = r_pat;
    w_exp_nxt      = r_exp;
    w_mask_nxt     = r_mask;
    w_resp_nxt     = r_resp;
    w_resp_out_nxt = r_resp_out;
    w_pass_nxt     = r_pass;
    w_se_nxt       = 1'b0;
    w_sdi_nxt      = 1'b0;
    w_busy_nxt     = 1'b0;
    w_done_nxt     = 1'b0;

    if (abort) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_state_nxt = S_SHIFT_IN;
            w_cnt_nxt   = '0;
            w_exp_nxt   = exp_in;
            w_mask_nxt  = mask_in;
            w_pat_nxt   = {pat_in[CHAIN_LEN-2:0], 1'b0};
            w_sdi_nxt   = pat_in[CHAIN_LEN-1];
            w_se_nxt    = 1'b1;
            w_busy_nxt  = 1'b1;
          end
        end

        S_SHIFT_IN: begin
          w_busy_nxt = 1'b1;
          if (r_cnt == c_last) begin
            w_state_nxt = S_CAPTURE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
            w_se_nxt  = 1'b1;
            w_sdi_nxt = r_pat[CHAIN_LEN-1];
            w_pat_nxt = {r_pat[CHAIN_LEN-2:0], 1'b0};
          end
        end

        S_CAPTURE: begin
          w_state_nxt = S_SHIFT_OUT;
          w_cnt_nxt   = '0;
          w_se_nxt    = 1'b1;
          w_busy_nxt  = 1'b1;
        end

        S_SHIFT_OUT: begin
          w_resp_nxt = w_resp_shift;
          if (r_cnt == c_last) begin
            w_state_nxt    = S_DONE;
            w_cnt_nxt      = '0;
            w_done_nxt     = 1'b1;
            w_pass_nxt     = w_cmp_ok;
            w_resp_out_nxt = w_resp_shift;
          end else begin
            w_cnt_nxt  = r_cnt + CNT_W'(1);
            w_se_nxt   = 1'b1;
            w_busy_nxt = 1'b1;
          end
        end

        S_DONE: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end

        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign scan_enable  = r_se;
  assign scan_data_in = r_sdi;
  assign busy         = r_busy;
  assign done         = r_done;
  assign pass         = r_pass;
  assign resp_out     = r_resp_out;

endmodule
`default_nettype wire

// File: tb/tb_scan_pattern_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_scan_pattern_ctrl
// Purpose  : Self-checking bench for scan_pattern_ctrl with a 16-flop chain
//            model whose capture is a bitwise invert.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scan_pattern_ctrl;

  localparam int c_n = 16;

  logic           CK;
  logic           RN;
  logic           start;
  logic           abort;
  logic [c_n-1:0] pat_in;
  logic [c_n-1:0] exp_in;
  logic [c_n-1:0] mask_in;
  logic           scan_data_out;
  logic           scan_enable;
  logic           scan_data_in;
  logic           busy;
  logic           done;
  logic           pass;
  logic [c_n-1:0] resp_out;

  int tests = 0;
  int fails = 0;

  // Scoreboard entries: {pass, resp}
  logic [c_n:0] sb [$];

  logic [c_n-1:0] r_chain = '0;

  scan_pattern_ctrl #(.CHAIN_LEN(c_n), .CNT_W(6)) dut (
    .CK            (CK),
    .RN            (RN),
    .start         (start),
    .abort         (abort),
    .pat_in        (pat_in),
    .exp_in        (exp_in),
    .mask_in       (mask_in),
    .scan_data_out (scan_data_out),
    .scan_enable   (scan_enable),
    .scan_data_in  (scan_data_in),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .resp_out      (resp_out)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  // Chain model: shift toward the MSB when enabled, invert on capture.
  always @(posedge CK) begin
    if (scan_enable) r_chain <= {r_chain[c_n-2:0], scan_data_in};
    else             r_chain <= ~r_chain;
  end
  assign scan_data_out = r_chain[c_n-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Completion monitor: every done pops one scoreboard entry.
  always @(negedge CK) begin
    if (done === 1'b1) begin
      chk("sb_has_entry", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        logic [c_n:0] e;
        e = sb.pop_front();
        chk("pass", {31'd0, pass}, {31'd0, e[c_n]});
        chk("resp_out", {16'd0, resp_out}, {16'd0, e[c_n-1:0]});
      end
    end
  end

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  // Expected pass/response under the invert-capture chain model.
  function automatic logic [c_n:0] model(input logic [c_n-1:0] p,
                                         input logic [c_n-1:0] e,
                                         input logic [c_n-1:0] m);
    logic [c_n-1:0] r;
    r = ~p;
    return {(((r ^ e) & m) == '0), r};
  endfunction

  // Per-cycle check; cc = cycles since the start-accepting edge.
  task automatic check_cycle(input int cc, input logic [c_n-1:0] p);
    logic e_se, e_sdi, e_busy, e_done;
    e_se   = (cc < c_n) || (cc >= c_n + 1 && cc <= 2*c_n);
    e_sdi  = (cc < c_n) ? p[c_n-1-cc] : 1'b0;
    e_busy = (cc <= 2*c_n);
    e_done = (cc == 2*c_n + 1);
    chk($sformatf("scan_enable@%0d", cc), {31'd0, scan_enable}, {31'd0, e_se});
    chk($sformatf("scan_data_in@%0d", cc), {31'd0, scan_data_in}, {31'd0, e_sdi});
    chk($sformatf("busy@%0d", cc), {31'd0, busy}, {31'd0, e_busy});
    chk($sformatf("done@%0d", cc), {31'd0, done}, {31'd0, e_done});
  endtask

  // Drive a one-cycle start, then scramble the inputs to prove they were latched.
  task automatic start_test(input logic [c_n-1:0] p, input logic [c_n-1:0] e,
                            input logic [c_n-1:0] m, input bit push);
    pat_in = p; exp_in = e; mask_in = m; start = 1'b1;
    if (push) sb.push_back(model(p, e, m));
    step();
    start = 1'b0;
    pat_in = ~p; exp_in = ~e; mask_in = ~m;
  endtask

  task automatic run_full(input logic [c_n-1:0] p, input logic [c_n-1:0] e,
                          input logic [c_n-1:0] m);
    start_test(p, e, m, 1'b1);
    for (int c = 0; c <= 2*c_n + 2; c++) begin
      check_cycle(c, p);
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout tests=%0d failed=%0d", tests, fails);
    $fatal(1, "timeout");
  end

  initial begin
    RN = 1'b0; start = 1'b0; abort = 1'b0;
    pat_in = '0; exp_in = '0; mask_in = '0;
    #12;
    chk("rst_scan_enable", {31'd0, scan_enable}, 32'd0);
    chk("rst_scan_data_in", {31'd0, scan_data_in}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
    chk("rst_resp_out", {16'd0, resp_out}, 32'd0);
    @(negedge CK);
    RN = 1'b1;
    step();

    // Basic functional runs, compare miss, masked compare, serial order.
    run_full(16'hA5C3, 16'h5A3C, 16'hFFFF);
    run_full(16'hA5C3, 16'h5A3D, 16'hFFFF);
    run_full(16'hA5C3, 16'h5A3D, 16'hFFFE);
    run_full(16'h8001, 16'h7FFE, 16'hFFFF);
    // All-zero mask: pass regardless of response.
    run_full(16'h1234, 16'h0000, 16'h0000);

    // Abort wins over start in IDLE.
    pat_in = 16'h1111; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("abort_vs_start_busy", {31'd0, busy}, 32'd0);
    chk("abort_vs_start_se", {31'd0, scan_enable}, 32'd0);

    // Abort on cycle 20; earlier result must be preserved.
    start_test(16'h0F0F, 16'hF0F0, 16'hFFFF, 1'b0);
    for (int c = 0; c < 20; c++) begin
      check_cycle(c, 16'h0F0F);
      step();
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_se", {31'd0, scan_enable}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    for (int c = 0; c < 40; c++) begin
      chk("abort_no_done", {31'd0, done}, 32'd0);
      step();
    end
    chk("abort_pass_kept", {31'd0, pass}, 32'd1);
    chk("abort_resp_kept", {16'd0, resp_out}, 32'h0000EDCB);
    run_full(16'h0F0F, 16'hF0F0, 16'hFFFF);

    // Asynchronous reset during SHIFT_OUT.
    start_test(16'h5555, 16'hAAAA, 16'hFFFF, 1'b0);
    for (int c = 0; c < 20; c++) begin
      check_cycle(c, 16'h5555);
      step();
    end
    #2;
    RN = 1'b0;
    #1;
    chk("arst_scan_enable", {31'd0, scan_enable}, 32'd0);
    chk("arst_scan_data_in", {31'd0, scan_data_in}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_pass", {31'd0, pass}, 32'd0);
    chk("arst_resp_out", {16'd0, resp_out}, 32'd0);
    @(negedge CK);
    RN = 1'b1;
    step();
    run_full(16'hFFFF, 16'h0000, 16'hFFFF);

    // start held high: back-to-back tests on a 35-cycle period.
    pat_in = 16'h3C3C; exp_in = 16'hC3C3; mask_in = 16'hFFFF; start = 1'b1;
    sb.push_back(model(16'h3C3C, 16'hC3C3, 16'hFFFF));
    sb.push_back(model(16'h3C3C, 16'hC3C3, 16'hFFFF));
    step();
    for (int c = 0; c <= 70; c++) begin
      if (c == 38) start = 1'b0;
      check_cycle((c < 35) ? c : c - 35, 16'h3C3C);
      step();
    end

    chk("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/scan_pattern_ctrl.md
Name: scan_pattern_ctrl

Overview:
- Tester-side scan sequencer that sits directly upstream and downstream of the scan-wrapped CDC block.
- Drives its scan_enable and scan_data_in, and consumes its scan_data_out.
- Per test: shifts one pattern into the chain, applies one capture cycle, shifts the response out, and compares it against an expected vector under a mask.
- Reports pass/fail and the raw captured response.

Parameters:
- CHAIN_LEN, 16, number of scan flops in the chain; legal range 2..64.
- CNT_W, 6, shift-counter width; must satisfy 2**CNT_W > CHAIN_LEN.

Ports:
- CK  input  1  clock; the single clock for this block and the chain it tests.
- RN  input  1  asynchronous reset, active low.
- start  input  1  one-cycle request to run one test; honoured only in IDLE.
- abort  input  1  terminates any running test.
- pat_in  input  CHAIN_LEN  stimulus; bit i is the value destined for chain position i (position 0 is nearest scan_data_in).
- exp_in  input  CHAIN_LEN  expected captured value per position.
- mask_in  input  CHAIN_LEN  1 = compare this position, 0 = don't care.
- scan_data_out  input  1  chain serial output (last flop Q).
- scan_enable  output  1  1 = chain shifts, 0 = functional capture.
- scan_data_in  output  1  serial data into the chain.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when a test completes.
- pass  output  1  compare result; valid and held from done until the next start.
- resp_out  output  CHAIN_LEN  captured response, bit i = chain position i; held until the next start.

Behaviour:
- Reset (RN=0, asynchronous): state IDLE; scan_enable=0, scan_data_in=0, busy=0, done=0, pass=0, resp_out=0, counter=0. All outputs are registered.
- IDLE, start=1 (and abort=0): latch pat_in, exp_in and mask_in into internal registers; go to SHIFT_IN; counter=0.
  - Inputs may change after the accepting cycle.
  - start in any non-IDLE state is ignored.
- SHIFT_IN, CHAIN_LEN cycles:
  - scan_enable=1, busy=1.
  - Cycle k (k=0..CHAIN_LEN-1) presents scan_data_in = pat[CHAIN_LEN-1-k].
  - After the last shift edge, chain position i holds pat[i].
  - Exit to CAPTURE when counter reaches CHAIN_LEN-1.
- CAPTURE, 1 cycle: scan_enable=0, scan_data_in=0. The chain loads functional values on this edge.
- SHIFT_OUT, CHAIN_LEN cycles:
  - scan_enable=1, scan_data_in=0.
  - On the edge ending cycle k, sample scan_data_out into resp[CHAIN_LEN-1-k].
  - The chain is zero-filled on exit.
- DONE, 1 cycle:
  - done=1, busy=0, scan_enable=0.
  - pass = (((resp ^ exp) & mask) == 0); resp_out = resp.
  - Then IDLE.
- Latency: start accepted at edge T.
  - scan_enable rises after edge T.
  - done is high for the single cycle after edge T+2*CHAIN_LEN+1.
  - Total test length is 2*CHAIN_LEN+2 cycles including DONE.
- abort=1 in any state: IDLE on the next edge; scan_enable=0, busy=0, no done pulse; pass and resp_out keep their previous values. Abort has priority over start in the same cycle.
- start and done coincident is impossible: start is only honoured in IDLE.
- The counter wraps to 0 at each state change and never exceeds CHAIN_LEN-1.
- mask_in all zero: pass=1 regardless of response.
- Reset asserted mid-test: immediate return to reset values, no done.
  - After RN deasserts, the chain contents are undefined until the next test.
  - The next start runs a complete, correct test.

Test Plan:
- CHAIN_LEN=16, chain replaced by a 16-bit shift register with capture = bitwise invert; pat_in=16'hA5C3, exp_in=16'h5A3C, mask_in=16'hFFFF, start pulse -> scan_enable high for 16 cycles, low 1, high 16; done at cycle 34 after start; resp_out=16'h5A3C, pass=1.
- Same setup, exp_in=16'h5A3D, mask_in=16'hFFFF -> pass=0, resp_out=16'h5A3C. Repeat with mask_in=16'hFFFE -> pass=1.
- Check the serial order on scan_data_in for pat_in=16'h8001 -> 1 on cycle 0, 0 on cycles 1..14, 1 on cycle 15; scan_data_in=0 during CAPTURE and SHIFT_OUT.
- abort asserted on cycle 20 of a test -> next edge: scan_enable=0, busy=0, no done ever; prior pass/resp_out unchanged. A following start completes normally with done at cycle 34.
- RN pulled low during SHIFT_OUT -> all outputs 0 asynchronously. After release, start with pat_in=16'hFFFF, invert-capture model, exp_in=0 -> pass=1.
- start held high for 40 cycles -> exactly one test runs, then a second one starts in the IDLE cycle after done; done pulses exactly once per 35-cycle period.
